// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle WIDTH-bit magnitude comparator that walks
// the operands DIGIT bits per cycle from the MSB and stops at the first
// differing digit. Unsigned or two's-complement compare.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           request a compare (taken only when busy=0)
//   signed_mode     1 = two's-complement, 0 = unsigned (latched with start)
//   A, B            operands (latched with start)
//   busy            compare in progress
//   done            one-cycle pulse when results update
//   A_gt_B/A_eq_B/A_lt_B  registered result flags, held until next done
//   cycles          digits examined by the last completed compare
module seq_comparator #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4,
   localparam int NDIG = WIDTH / DIGIT,
   localparam int CW = $clog2(NDIG) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             A_gt_B,
   output logic             A_eq_B,
   output logic             A_lt_B,
   output logic [CW-1:0]    cycles
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic {
      IDLE,
      CMP
   } state_t;

   state_t state_q, state_d;

   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sm_q, sm_d;
   logic             busy_d, done_d;
   logic             gt_d, eq_d, lt_d;
   logic [CW-1:0]    cyc_d;
   logic [DIGIT-1:0] da, db;
   logic             top;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         A_gt_B  <= 1'b0;
         A_eq_B  <= 1'b0;
         A_lt_B  <= 1'b0;
         cycles  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sm_q    <= sm_d;
         busy    <= busy_d;
         done    <= done_d;
         A_gt_B  <= gt_d;
         A_eq_B  <= eq_d;
         A_lt_B  <= lt_d;
         cycles  <= cyc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      busy_d  = busy;
      done_d  = 1'b0;
      gt_d    = A_gt_B;
      eq_d    = A_eq_B;
      lt_d    = A_lt_B;
      cyc_d   = cycles;

      da  = DIGIT'(a_q >> (int'(idx_q) * DIGIT));
      db  = DIGIT'(b_q >> (int'(idx_q) * DIGIT));
      top = (idx_q == IW'(NDIG - 1));

      // Flipping the sign bit of the top digit maps two's-complement
      // ordering onto unsigned ordering; lower digits carry no sign.
      if (sm_q && top) begin
         da[DIGIT-1] = ~da[DIGIT-1];
         db[DIGIT-1] = ~db[DIGIT-1];
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               sm_d    = signed_mode;
               idx_d   = IW'(NDIG - 1);
               busy_d  = 1'b1;
               state_d = CMP;
            end
         end
         CMP: begin
            if (da != db) begin
               gt_d    = (da > db);
               lt_d    = (da < db);
               eq_d    = 1'b0;
               cyc_d   = CW'(NDIG - int'(idx_q));
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (idx_q == '0) begin
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               eq_d    = 1'b1;
               cyc_d   = CW'(NDIG);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
